// File: rtl/pipeline_resource_mul_if.sv
// Handshake bundle for pipeline_resource_mul: request side (stage 3) and response side (stage 4).
// slave = the multiplier's view, master = the surrounding pipeline's view.
interface pipeline_resource_mul_if;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_flush;
  logic        out_stall;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_flush;
  logic        in_stall;

  modport slave (
    input  in_data, in_valid, in_flush, in_stall,
    output out_stall, out_data, out_valid, out_flush
  );

  modport master (
    output in_data, in_valid, in_flush, in_stall,
    input  out_stall, out_data, out_valid, out_flush
  );
endinterface

// File: rtl/pipeline_resource_mul.sv
// Iterative shift-add 16x16 unsigned multiplier, one op in flight, valid/stall/flush handshake.
// Optional perf counters (op_count, stall_count) enabled by defining RESOURCE_MUL_PERF_CNT_EN.
module pipeline_resource_mul #(
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  pipeline_resource_mul_if.slave bus
`ifdef RESOURCE_MUL_PERF_CNT_EN
  ,
  output logic [31:0]            op_count,
  output logic [31:0]            stall_count
`endif
);
  localparam int         LAT       = 16 / BITS_PER_CYCLE;
  localparam logic [4:0] LAST_STEP = 5'(LAT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_BUSY, ST_DONE} state_t;

  state_t      state_q, state_d;
  logic [31:0] a_q, a_d;
  logic [15:0] b_q, b_d;
  logic [31:0] acc_q, acc_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;
  logic        out_flush_q, out_flush_d;

  logic        out_stall;
  logic        accept;
  logic        last_step;
  logic [31:0] psum [0:BITS_PER_CYCLE];

  // Stall depends only on registered state and the downstream stall, never on in_valid/in_data.
  assign out_stall = (state_q == ST_BUSY) || ((state_q == ST_DONE) && bus.in_stall);
  assign accept    = bus.in_valid && !out_stall && !bus.in_flush;
  assign last_step = (cnt_q == LAST_STEP);

  assign psum[0] = acc_q;
  for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_pp
    assign psum[gi+1] = psum[gi] + (b_q[gi] ? (a_q << gi) : 32'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_flush_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
      out_flush_q <= out_flush_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (bus.in_flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = ST_BUSY;
        ST_BUSY: if (last_step) state_d = ST_DONE;
        ST_DONE: if (!bus.in_stall) state_d = accept ? ST_BUSY : ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    out_flush_d = bus.in_flush;
    if (bus.in_flush) begin
      // Abort the partial product; out_data deliberately keeps the last completed result.
      out_valid_d = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
    end else if (state_q == ST_BUSY) begin
      acc_d = psum[BITS_PER_CYCLE];
      a_d   = a_q << BITS_PER_CYCLE;
      b_d   = b_q >> BITS_PER_CYCLE;
      cnt_d = cnt_q + 5'd1;
      if (last_step) begin
        out_data_d  = psum[BITS_PER_CYCLE];
        out_valid_d = 1'b1;
      end
    end else begin
      if ((state_q == ST_DONE) && !bus.in_stall) out_valid_d = 1'b0;
      if (accept) begin
        a_d   = {16'd0, bus.in_data[15:0]};
        b_d   = bus.in_data[31:16];
        acc_d = '0;
        cnt_d = '0;
      end
    end
  end

  assign bus.out_stall = out_stall;
  assign bus.out_data  = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_flush = out_flush_q;

`ifdef RESOURCE_MUL_PERF_CNT_EN
  logic [31:0] op_cnt_q, op_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      op_cnt_q    <= '0;
      stall_cnt_q <= '0;
    end else begin
      op_cnt_q    <= op_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_comb begin
    op_cnt_d    = op_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if ((state_q == ST_DONE) && !bus.in_stall && !bus.in_flush) op_cnt_d = op_cnt_q + 32'd1;
    if ((state_q == ST_DONE) && bus.in_stall) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  assign op_count    = op_cnt_q;
  assign stall_count = stall_cnt_q;
`endif
endmodule
